// File: rtl/vita49_pkg.sv
// Shared constants, state encoding and header helpers for the VITA-49 IF-data packer.
package vita49_pkg;

    localparam int CTRL_START    = 0;
    localparam int CTRL_SOFT_RST = 1;
    localparam int CTRL_PASS     = 2;
    localparam int CTRL_TRL_EN   = 3;
    localparam int CTRL_TS_EN    = 4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_PASS    = 1;
    localparam int STAT_CFG_ERR = 2;

    localparam logic [3:0] PKT_TYPE   = 4'b0001;
    localparam logic [1:0] TS_NONE    = 2'b00;
    localparam logic [1:0] TSI_UTC    = 2'b01;
    localparam logic [1:0] TSF_SAMPLE = 2'b01;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR,
        ST_SID,
        ST_TSI,
        ST_TSF_HI,
        ST_TSF_LO,
        ST_PAY,
        ST_TRL,
        ST_PASS
    } state_t;

    // Smallest legal packet: header + stream ID + optional timestamps + optional trailer + one payload word.
    function automatic logic [15:0] min_pkt_size(input logic ts_en, input logic trl_en);
        return 16'(3 + (ts_en ? 3 : 0) + (trl_en ? 1 : 0));
    endfunction

    function automatic logic [31:0] make_header(input logic ts_en, input logic trl_en,
                                                input logic [3:0] cnt, input logic [15:0] size);
        return {PKT_TYPE, 1'b0, trl_en, 2'b00,
                ts_en ? TSI_UTC : TS_NONE, ts_en ? TSF_SAMPLE : TS_NONE, cnt, size};
    endfunction

endpackage

// File: rtl/vita49_axis_slice.sv
// One-entry registered output stage; upstream may load whenever the entry is empty or draining.
module vita49_axis_slice (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready
);

    // Ready is taken from the downstream combinationally, so a single entry never overflows.
    assign in_ready = out_ready | ~out_valid;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/vita49_packer.sv
// VITA-49 IF-data packet framer (header, stream ID, optional timestamps, payload, optional trailer).
// Define VITA49_PASSTHROUGH_EN to enable the raw passthrough mode selected by ctrl[2].
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start (or passthrough request)
// ST_HDR    | emitting header word, latching timestamps
// ST_SID    | emitting stream ID word
// ST_TSI    | emitting integer-seconds timestamp
// ST_TSF_HI | emitting fractional timestamp [63:32]
// ST_TSF_LO | emitting fractional timestamp [31:0]
// ST_PAY    | forwarding payload beats, down-counting to terminal count
// ST_TRL    | emitting trailer word (TLAST)
// ST_PASS   | raw passthrough, S side wired straight to M side
module vita49_packer
    import vita49_pkg::*;
(
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic [31:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic        S_AXIS_TLAST,
    output logic [31:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic        M_AXIS_TLAST,
    input  logic [31:0] ctrl,
    output logic [31:0] status,
    input  logic [31:0] streamID,
    input  logic [15:0] pkt_size,
    input  logic [31:0] trailer,
    input  logic [31:0] timestamp_sec,
    input  logic [63:0] timestamp_fsec
);

    state_t      state_q, state_d;
    logic        rst_b;
    logic        ts_en_q, trl_en_q, cfg_err_q;
    logic [31:0] sid_q, tsi_q;
    logic [63:0] tsf_q;
    logic [15:0] size_q, pay_cnt_q, sent_q;
    logic [3:0]  pkt_cnt_q;

    logic        w_valid, w_last, w_ready;
    logic [31:0] w_data;
    logic        sl_valid, sl_last;
    logic [31:0] sl_data;
    logic        load_cfg, ts_load, pay_beat, pkt_done, err_set, s_ready_framed;
    logic        cfg_bad, pt_req, pass_active;
    logic        unused_ctrl;

    assign rst_b   = AXIS_ARESETN & ~ctrl[CTRL_SOFT_RST];
    assign cfg_bad = pkt_size < min_pkt_size(ctrl[CTRL_TS_EN], ctrl[CTRL_TRL_EN]);

`ifdef VITA49_PASSTHROUGH_EN
    assign pt_req = ctrl[CTRL_PASS];
`else
    assign pt_req = 1'b0;
`endif

    assign unused_ctrl = ^{ctrl[31:5], ctrl[CTRL_PASS]};

    always_comb begin
        state_d        = state_q;
        w_valid        = 1'b0;
        w_data         = '0;
        w_last         = 1'b0;
        load_cfg       = 1'b0;
        ts_load        = 1'b0;
        pay_beat       = 1'b0;
        pkt_done       = 1'b0;
        err_set        = 1'b0;
        s_ready_framed = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Passthrough waits for the slice to drain so no framed word is dropped.
                if (pt_req) begin
                    if (!sl_valid) state_d = ST_PASS;
                end else if (ctrl[CTRL_START]) begin
                    if (cfg_bad) begin
                        err_set = 1'b1;
                    end else begin
                        load_cfg = 1'b1;
                        state_d  = ST_HDR;
                    end
                end
            end
            ST_HDR: begin
                w_valid = 1'b1;
                w_data  = make_header(ts_en_q, trl_en_q, pkt_cnt_q, size_q);
                if (w_ready) begin
                    ts_load = 1'b1;
                    state_d = ST_SID;
                end
            end
            ST_SID: begin
                w_valid = 1'b1;
                w_data  = sid_q;
                if (w_ready) state_d = ts_en_q ? ST_TSI : ST_PAY;
            end
            ST_TSI: begin
                w_valid = 1'b1;
                w_data  = tsi_q;
                if (w_ready) state_d = ST_TSF_HI;
            end
            ST_TSF_HI: begin
                w_valid = 1'b1;
                w_data  = tsf_q[63:32];
                if (w_ready) state_d = ST_TSF_LO;
            end
            ST_TSF_LO: begin
                w_valid = 1'b1;
                w_data  = tsf_q[31:0];
                if (w_ready) state_d = ST_PAY;
            end
            ST_PAY: begin
                w_valid        = S_AXIS_TVALID;
                w_data         = S_AXIS_TDATA;
                w_last         = ~trl_en_q && (pay_cnt_q == '0);
                s_ready_framed = w_ready;
                if (S_AXIS_TVALID && w_ready) begin
                    pay_beat = 1'b1;
                    if (pay_cnt_q == '0) begin
                        if (trl_en_q) state_d  = ST_TRL;
                        else          pkt_done = 1'b1;
                    end
                end
            end
            ST_TRL: begin
                w_valid = 1'b1;
                w_data  = trailer;
                w_last  = 1'b1;
                if (w_ready) pkt_done = 1'b1;
            end
            ST_PASS: begin
                if (!pt_req && !S_AXIS_TVALID) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (pkt_done) begin
            if (!ctrl[CTRL_START]) begin
                state_d = ST_IDLE;
            end else if (cfg_bad) begin
                err_set = 1'b1;
                state_d = ST_IDLE;
            end else begin
                load_cfg = 1'b1;
                state_d  = ST_HDR;
            end
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!rst_b) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!rst_b) begin
            ts_en_q   <= 1'b0;
            trl_en_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            sid_q     <= '0;
            tsi_q     <= '0;
            tsf_q     <= '0;
            size_q    <= '0;
            pay_cnt_q <= '0;
            sent_q    <= '0;
            pkt_cnt_q <= '0;
        end else begin
            if (load_cfg) begin
                ts_en_q   <= ctrl[CTRL_TS_EN];
                trl_en_q  <= ctrl[CTRL_TRL_EN];
                sid_q     <= streamID;
                size_q    <= pkt_size;
                pay_cnt_q <= pkt_size - min_pkt_size(ctrl[CTRL_TS_EN], ctrl[CTRL_TRL_EN]);
            end else if (pay_beat) begin
                pay_cnt_q <= pay_cnt_q - 16'd1;
            end
            if (ts_load) begin
                tsi_q <= timestamp_sec;
                tsf_q <= timestamp_fsec;
            end
            if (pkt_done) begin
                pkt_cnt_q <= pkt_cnt_q + 4'd1;
                sent_q    <= sent_q + 16'd1;
            end
            if (err_set)       cfg_err_q <= 1'b1;
            else if (load_cfg) cfg_err_q <= 1'b0;
        end
    end

    vita49_axis_slice u_slice (
        .clk       (AXIS_ACLK),
        .rst_b     (rst_b),
        .in_valid  (w_valid),
        .in_data   (w_data),
        .in_last   (w_last),
        .in_ready  (w_ready),
        .out_valid (sl_valid),
        .out_data  (sl_data),
        .out_last  (sl_last),
        .out_ready (M_AXIS_TREADY)
    );

    assign pass_active   = (state_q == ST_PASS);
    assign M_AXIS_TVALID = pass_active ? S_AXIS_TVALID : sl_valid;
    assign M_AXIS_TDATA  = pass_active ? S_AXIS_TDATA  : sl_data;
    assign M_AXIS_TLAST  = pass_active ? S_AXIS_TLAST  : sl_last;
    assign S_AXIS_TREADY = pass_active ? M_AXIS_TREADY : s_ready_framed;

    assign status = {sent_q, 8'h00, pkt_cnt_q, 1'b0, cfg_err_q, pass_active, state_q != ST_IDLE};

endmodule

// File: tb/tb_vita49_packer.sv
// Self-checking bench for vita49_packer: config table, directed framing runs and randomized
// backpressure runs checked against a packet-stream model.
module tb_vita49_packer;

    logic        AXIS_ACLK = 1'b0;
    logic        AXIS_ARESETN;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic        S_AXIS_TLAST;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [31:0] streamID;
    logic [15:0] pkt_size;
    logic [31:0] trailer;
    logic [31:0] timestamp_sec;
    logic [63:0] timestamp_fsec;

    int n_tests = 0;
    int n_fail  = 0;
    int m_cnt, m_sent, m_pkts;
    logic [31:0] src_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] rcv_q[$];

    typedef struct {
        logic [31:0] c;
        logic [15:0] sz;
        logic        err;
        logic        busy;
    } cfg_vec_t;
    cfg_vec_t tbl[10];
    int cfgs[4] = '{1, 9, 17, 25};
    logic [31:0] rc;
    logic [15:0] rsz;
    int rnw;

    always #5 AXIS_ACLK = ~AXIS_ACLK;

    vita49_packer dut (
        .AXIS_ACLK      (AXIS_ACLK),
        .AXIS_ARESETN   (AXIS_ARESETN),
        .S_AXIS_TDATA   (S_AXIS_TDATA),
        .S_AXIS_TVALID  (S_AXIS_TVALID),
        .S_AXIS_TREADY  (S_AXIS_TREADY),
        .S_AXIS_TLAST   (S_AXIS_TLAST),
        .M_AXIS_TDATA   (M_AXIS_TDATA),
        .M_AXIS_TVALID  (M_AXIS_TVALID),
        .M_AXIS_TREADY  (M_AXIS_TREADY),
        .M_AXIS_TLAST   (M_AXIS_TLAST),
        .ctrl           (ctrl),
        .status         (status),
        .streamID       (streamID),
        .pkt_size       (pkt_size),
        .trailer        (trailer),
        .timestamp_sec  (timestamp_sec),
        .timestamp_fsec (timestamp_fsec)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr_word(input logic [31:0] c, input int sz, input int cnt);
        return 32'h1000_0000 + (c[3] ? 32'h0400_0000 : 32'h0) + (c[4] ? 32'h0050_0000 : 32'h0)
               + 32'((cnt % 16) << 16) + 32'(sz);
    endfunction

    // Expected output stream: whole packets built from the framing rules, cut off where input runs dry.
    function automatic void build_model(input logic [31:0] c, input int sz, input int nw, input int maxp);
        int ts, t, n, k;
        ts = c[4] ? 1 : 0;
        t  = c[3] ? 1 : 0;
        n  = sz - 2 - 3 * ts - t;
        k  = 0;
        exp_q.delete();
        m_pkts = 0;
        for (int p = 0; p < maxp; p++) begin
            exp_q.push_back({1'b0, hdr_word(c, sz, m_cnt + p)});
            exp_q.push_back({1'b0, streamID});
            if (ts == 1) begin
                exp_q.push_back({1'b0, timestamp_sec});
                exp_q.push_back({1'b0, timestamp_fsec[63:32]});
                exp_q.push_back({1'b0, timestamp_fsec[31:0]});
            end
            for (int j = 0; j < n; j++) begin
                if (k >= nw) return;
                exp_q.push_back({(t == 0) && (j == n - 1), src_q[k]});
                k++;
            end
            if (t == 1) exp_q.push_back({1'b1, trailer});
            m_pkts++;
        end
    endfunction

    task automatic soft_reset();
        @(negedge AXIS_ACLK);
        ctrl          = 32'h2;
        S_AXIS_TVALID = 1'b0;
        M_AXIS_TREADY = 1'b0;
        @(negedge AXIS_ACLK);
        ctrl   = 32'h0;
        m_cnt  = 0;
        m_sent = 0;
    endtask

    task automatic run_stream(input string nm, input logic [31:0] c, input logic [15:0] sz, input int nw,
                              input bit counting, input int vprob, input int rprob,
                              input int clr_at, input int maxp);
        int si, got, extra, cyc, drain;
        soft_reset();
        src_q.delete();
        rcv_q.delete();
        for (int i = 0; i < nw; i++) src_q.push_back(counting ? 32'(i) : $urandom());
        build_model(c, int'(sz), nw, maxp);
        si = 0; got = 0; extra = 0; cyc = 0; drain = 0;
        ctrl     = c;
        pkt_size = sz;
        while (drain < 30 && cyc < 20000) begin
            @(negedge AXIS_ACLK);
            if (clr_at >= 0 && si >= clr_at) ctrl[0] = 1'b0;
            S_AXIS_TVALID = (si < nw) && ($urandom_range(99) < vprob);
            S_AXIS_TDATA  = (si < nw) ? src_q[si] : 32'h0;
            S_AXIS_TLAST  = 1'($urandom_range(1));
            M_AXIS_TREADY = (got >= exp_q.size()) || ($urandom_range(99) < rprob);
            #1;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                if (got < exp_q.size())
                    check($sformatf("%s word %0d", nm, got), {M_AXIS_TLAST, M_AXIS_TDATA}, exp_q[got]);
                else
                    extra++;
                rcv_q.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
                got++;
            end
            if (S_AXIS_TVALID && S_AXIS_TREADY) si++;
            if (got >= exp_q.size()) drain++;
            cyc++;
        end
        check({nm, " timeout"}, cyc >= 20000, 0);
        check({nm, " extra_words"}, extra, 0);
        m_cnt  = (m_cnt + m_pkts) % 16;
        m_sent = m_pkts;
        check({nm, " pkt_count"}, status[7:4], m_cnt);
        check({nm, " pkts_sent"}, status[31:16], m_sent);
        check({nm, " busy"}, status[0], clr_at < 0);
        S_AXIS_TVALID = 1'b0;
    endtask

    initial begin
        AXIS_ARESETN   = 1'b0;
        ctrl           = 32'h1;
        S_AXIS_TDATA   = 32'h0;
        S_AXIS_TVALID  = 1'b0;
        S_AXIS_TLAST   = 1'b0;
        M_AXIS_TREADY  = 1'b1;
        streamID       = 32'hDEAD_BEEF;
        pkt_size       = 16'h20;
        trailer        = 32'h40;
        timestamp_sec  = 32'h1234_5678;
        timestamp_fsec = 64'h0000_0001_0000_0002;

        repeat (3) @(negedge AXIS_ACLK);
        #1;
        check("reset_status", status, 0);
        check("reset_outputs", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY}, 0);
        ctrl = 32'h0;
        @(negedge AXIS_ACLK);
        AXIS_ARESETN = 1'b1;

        tbl[0] = '{32'h11, 16'd4, 1'b1, 1'b0};
        tbl[1] = '{32'h11, 16'd5, 1'b1, 1'b0};
        tbl[2] = '{32'h11, 16'd6, 1'b0, 1'b1};
        tbl[3] = '{32'h19, 16'd6, 1'b1, 1'b0};
        tbl[4] = '{32'h19, 16'd7, 1'b0, 1'b1};
        tbl[5] = '{32'h01, 16'd2, 1'b1, 1'b0};
        tbl[6] = '{32'h01, 16'd3, 1'b0, 1'b1};
        tbl[7] = '{32'h09, 16'd3, 1'b1, 1'b0};
        tbl[8] = '{32'h09, 16'd4, 1'b0, 1'b1};
        tbl[9] = '{32'h00, 16'd0, 1'b0, 1'b0};
        foreach (tbl[i]) begin
            soft_reset();
            ctrl     = tbl[i].c;
            pkt_size = tbl[i].sz;
            repeat (4) @(negedge AXIS_ACLK);
            #1;
            check($sformatf("cfg%0d cfg_err", i), status[2], tbl[i].err);
            check($sformatf("cfg%0d busy", i), status[0], tbl[i].busy);
            check($sformatf("cfg%0d out_valid", i), M_AXIS_TVALID, tbl[i].busy);
            if (tbl[i].busy) check($sformatf("cfg%0d hdr", i), M_AXIS_TDATA, hdr_word(tbl[i].c, int'(tbl[i].sz), 0));
        end

        // Timestamps + trailer, 256 counting words: 9 full packets, 10th stalls after 22 payload words.
        run_stream("t1", 32'h19, 16'h20, 256, 1'b1, 100, 100, -1, 1000);
        check("t1 hdr0", rcv_q[0], {1'b0, 32'h1450_0020});
        check("t1 trl0", rcv_q[31], {1'b1, 32'h0000_0040});
        check("t1 hdr1", rcv_q[32], {1'b0, 32'h1451_0020});
        check("t1 words", rcv_q.size(), 315);

        run_stream("t2a", 32'h01, 16'h20, 60, 1'b1, 100, 100, -1, 1000);
        check("t2a hdr0", rcv_q[0], {1'b0, 32'h1000_0020});
        check("t2a last", rcv_q[31], {1'b1, 32'd29});
        check("t2a words", rcv_q.size(), 66);
        trailer = 32'hCAFE_0009;
        run_stream("t2b", 32'h09, 16'h20, 58, 1'b1, 100, 100, -1, 1000);
        check("t2b hdr0", rcv_q[0], {1'b0, 32'h1400_0020});
        check("t2b trl", rcv_q[31], {1'b1, 32'hCAFE_0009});

        for (int it = 0; it < 6; it++) begin
            rc             = 32'(cfgs[$urandom_range(3)]);
            rsz            = 16'($urandom_range(40, 7));
            rnw            = int'($urandom_range(120, 20));
            streamID       = $urandom();
            trailer        = $urandom();
            timestamp_sec  = $urandom();
            timestamp_fsec = {$urandom(), $urandom()};
            run_stream($sformatf("rnd%0d", it), rc, rsz, rnw, 1'b0, 50, 50, -1, 1000);
        end

        run_stream("t4", 32'h01, 16'd7, 85, 1'b0, 60, 60, -1, 1000);
        check("t4 hdr17", rcv_q[16 * 7], {1'b0, 32'h1000_0007});
        check("t4 sent", status[31:16], 17);

        run_stream("stop", 32'h01, 16'd10, 20, 1'b0, 70, 70, 3, 1);

        // Soft reset while a packet is in flight.
        soft_reset();
        pkt_size      = 16'd8;
        ctrl          = 32'h1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'hA5A5_0000;
        M_AXIS_TREADY = 1'b1;
        repeat (20) @(negedge AXIS_ACLK);
        M_AXIS_TREADY = 1'b0;
        repeat (2) @(negedge AXIS_ACLK);
        #1;
        check("pre_abort count", status[7:4], 2);
        check("pre_abort valid", M_AXIS_TVALID, 1);
        ctrl = 32'h2;
        @(negedge AXIS_ACLK);
        #1;
        check("abort outputs", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, S_AXIS_TREADY}, 0);
        check("abort status", status, 0);
        ctrl          = 32'h1;
        S_AXIS_TVALID = 1'b0;
        repeat (4) @(negedge AXIS_ACLK);
        #1;
        check("restart hdr", M_AXIS_TDATA, 32'h1000_0008);

`ifdef VITA49_PASSTHROUGH_EN
        soft_reset();
        ctrl = 32'h4;
        repeat (2) @(negedge AXIS_ACLK);
        #1;
        check("pass active", status[1], 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge AXIS_ACLK);
            S_AXIS_TDATA  = $urandom();
            S_AXIS_TVALID = 1'($urandom_range(1));
            S_AXIS_TLAST  = 1'($urandom_range(1));
            M_AXIS_TREADY = 1'($urandom_range(1));
            #1;
            check($sformatf("pass beat %0d", i), {M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, S_AXIS_TREADY},
                  {S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY});
        end
        @(negedge AXIS_ACLK);
        ctrl          = 32'h0;
        S_AXIS_TVALID = 1'b0;
        repeat (2) @(negedge AXIS_ACLK);
        #1;
        check("pass exit", status[1:0], 0);
`else
        soft_reset();
        ctrl          = 32'h4;
        S_AXIS_TVALID = 1'b1;
        M_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge AXIS_ACLK);
        #1;
        check("pass ignored status", status[1:0], 0);
        check("pass ignored outputs", {M_AXIS_TVALID, S_AXIS_TREADY}, 0);
        S_AXIS_TVALID = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
